// File: rtl/unified_mem_ctrl.sv
// Shared single-port word memory serving an instruction-fetch channel and a
// load/store channel, with round-robin arbitration and programmable latency.
module unified_mem_ctrl #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 12,
    parameter int unsigned       LATENCY    = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h8000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   i_rsp_data,
    output logic                i_rsp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_wen,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    output logic                d_rsp_valid,
    input  logic                d_rsp_ready,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                d_rsp_err
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_d_q, last_d_d;
    logic                own_d_q, wen_q, err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                grant_d_c, accept_c, fire_c, rsp_ack_c, err_c;
    logic                acc_wen_c;
    logic [ADDR_W-1:0]   acc_addr_c, off_c;
    logic [DATA_W-1:0]   acc_wdata_c;
    logic [MASK_W-1:0]   acc_wmask_c;
    logic [DEPTH_LOG2-1:0] idx_c;

    // Data wins only when fetch is idle or fetch was granted last.
    assign grant_d_c = d_req_valid & (~i_req_valid | ~last_d_q);
    assign accept_c  = rst & (state_q == IDLE) & (i_req_valid | d_req_valid);
    assign rsp_ack_c = own_d_q ? d_rsp_ready : i_rsp_ready;

    // With LATENCY == 1 the access happens on the accepting edge, so use live inputs.
    assign acc_addr_c  = (state_q == IDLE) ? (grant_d_c ? d_req_addr : i_req_addr) : addr_q;
    assign acc_wen_c   = (state_q == IDLE) ? (grant_d_c & d_req_wen) : wen_q;
    assign acc_wdata_c = (state_q == IDLE) ? d_req_wdata : wdata_q;
    assign acc_wmask_c = (state_q == IDLE) ? d_req_wmask : wmask_q;

    assign off_c  = acc_addr_c - BASE_ADDR;
    assign err_c  = (|acc_addr_c[1:0]) | (|(off_c >> (DEPTH_LOG2 + 2)));
    assign idx_c  = off_c[DEPTH_LOG2+1:2];
    assign fire_c = (accept_c && (LATENCY == 1)) || (state_q == WAIT && cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    last_d_d = grant_d_c;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (rsp_ack_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        i_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        i_rsp_data  = '0;
        d_rsp_data  = '0;
        i_rsp_err   = 1'b0;
        d_rsp_err   = 1'b0;
        if (accept_c) begin
            i_req_ready = ~grant_d_c;
            d_req_ready = grant_d_c;
        end
        if (state_q == RESP) begin
            if (own_d_q) begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = rdata_q;
                d_rsp_err   = err_q;
            end else begin
                i_rsp_valid = 1'b1;
                i_rsp_data  = rdata_q;
                i_rsp_err   = err_q;
            end
        end
    end

    // Request capture on handshake, response capture on the edge entering RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_d_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                own_d_q <= grant_d_c;
                wen_q   <= acc_wen_c;
                addr_q  <= acc_addr_c;
                wdata_q <= d_req_wdata;
                wmask_q <= d_req_wmask;
            end
            if (fire_c) begin
                rdata_q <= (acc_wen_c || err_c) ? '0 : mem_q[idx_c];
                err_q   <= err_c;
            end
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (fire_c && acc_wen_c && !err_c) begin
            for (int unsigned b = 0; b < MASK_W; b++) begin
                if (acc_wmask_c[b]) mem_q[idx_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl: drivers push expected responses from a
// word-array reference model, a negedge monitor pops and compares them.
module tb_unified_mem_ctrl;
    localparam int unsigned LAT  = 2;
    localparam int unsigned DL2  = 12;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        bit          ch;
        logic [31:0] data;
        bit          err;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_wen, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [3:0]  d_req_wmask;

    unified_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(DL2), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wen(d_req_wen),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_pass = 0, n_total = 0;
    exp_t        sb[$];
    bit          grant_log[$];
    logic [31:0] mdl [int unsigned];
    bit          rand_bp = 1'b0;
    int unsigned d_ack_cyc = 0, i_hs_cyc = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(string name);
        n_total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic bit addr_err(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(4 << DL2));
    endfunction

    // Reference model: applied at the handshake, in acceptance order.
    task automatic model_accept(bit ch, bit wen, logic [31:0] a, logic [31:0] wd, logic [3:0] m);
        exp_t        e;
        int unsigned idx;
        e.ch   = ch;
        e.err  = addr_err(a);
        e.due  = cyc + LAT;
        e.data = '0;
        idx    = (a - BASE) >> 2;
        if (!e.err) begin
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                e.data = mdl[idx];
            end
        end
        sb.push_back(e);
        grant_log.push_back(ch);
    endtask

    task automatic drv_i(logic [31:0] a);
        bit ok = 1'b0;
        @(posedge clk); #1;
        i_req_valid = 1'b1;
        i_req_addr  = a;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (i_req_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) fail_now("i_req_timeout");
        else begin
            i_hs_cyc = cyc;
            model_accept(1'b0, 1'b0, a, 32'h0, 4'h0);
        end
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
    endtask

    task automatic drv_d(bit wen, logic [31:0] a, logic [31:0] wd, logic [3:0] m);
        bit ok = 1'b0;
        @(posedge clk); #1;
        d_req_valid = 1'b1;
        d_req_wen   = wen;
        d_req_addr  = a;
        d_req_wdata = wd;
        d_req_wmask = m;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (d_req_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) fail_now("d_req_timeout");
        else model_accept(1'b1, wen, a, wd, m);
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        d_req_wen   = 1'($urandom);
        d_req_addr  = $urandom;
        d_req_wdata = $urandom;
        d_req_wmask = 4'($urandom);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_i_req_ready"}, 32'(i_req_ready), 32'h0);
        check({tag, "_d_req_ready"}, 32'(d_req_ready), 32'h0);
        check({tag, "_i_rsp_valid"}, 32'(i_rsp_valid), 32'h0);
        check({tag, "_d_rsp_valid"}, 32'(d_rsp_valid), 32'h0);
        check({tag, "_i_rsp_err"},   32'(i_rsp_err),   32'h0);
        check({tag, "_d_rsp_err"},   32'(d_rsp_err),   32'h0);
        check({tag, "_i_rsp_data"},  i_rsp_data,       32'h0);
        check({tag, "_d_rsp_data"},  d_rsp_data,       32'h0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r, k;
        r = $urandom_range(0, 9);
        k = $urandom_range(0, 15);
        if (r < 8)  return BASE + 32'(4 * k);
        if (r == 8) return BASE + 32'(4 * k) + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) return BASE + 32'h4000 + 32'(4 * k);
        return BASE - 32'(4 * k + 4);
    endfunction

    // Monitor: pops on the first cycle of each response, checks hold while stalled.
    bit          pv = 1'b0, phs = 1'b0, pch = 1'b0, perr = 1'b0;
    logic [31:0] pdata = '0;
    always @(negedge clk) begin
        bit          v, ch, err, rdy;
        logic [31:0] data;
        exp_t        e;
        if (!rst) begin
            sb.delete();
            pv = 1'b0;
        end else begin
            v    = i_rsp_valid | d_rsp_valid;
            ch   = d_rsp_valid;
            data = ch ? d_rsp_data : i_rsp_data;
            err  = ch ? d_rsp_err : i_rsp_err;
            rdy  = ch ? d_rsp_ready : i_rsp_ready;
            if (i_rsp_valid && d_rsp_valid) fail_now("both_rsp_valid");
            if (i_req_ready && d_req_ready) fail_now("both_req_ready");
            if ((i_req_ready && !i_req_valid) || (d_req_ready && !d_req_valid)) fail_now("ready_without_valid");
            if (v) begin
                if (!pv || phs) begin
                    if (sb.size() == 0) fail_now("unexpected_rsp");
                    else begin
                        e = sb.pop_front();
                        check("rsp_channel", 32'(ch), 32'(e.ch));
                        check("rsp_data", data, e.data);
                        check("rsp_err", 32'(err), 32'(e.err));
                        check("rsp_latency_cycle", cyc, e.due);
                    end
                end else begin
                    check("hold_channel", 32'(ch), 32'(pch));
                    check("hold_data", data, pdata);
                    check("hold_err", 32'(err), 32'(perr));
                end
                if (rdy && ch) d_ack_cyc = cyc;
            end
            pv    = v;
            phs   = v && rdy;
            pch   = ch;
            pdata = data;
            perr  = err;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_bp) begin
                i_rsp_ready = ($urandom_range(0, 3) != 0);
                d_rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        bit          exp_rr[4];
        logic [31:0] old9;
        rst = 1'b1;
        i_req_valid = 1'b1; i_req_addr = BASE;
        d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = BASE; d_req_wdata = '0; d_req_wmask = '0;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Preload the 16 words the rest of the bench touches.
        for (int w = 0; w < 16; w++) begin
            logic [31:0] val;
            val = (w == 0) ? 32'h0000_0413 : (w == 4) ? 32'h1122_3344 : $urandom;
            drv_d(1'b1, BASE + 32'(4 * w), val, 4'hF);
        end

        drv_i(BASE);
        drv_d(1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101);
        drv_d(1'b0, BASE + 32'h10, 32'h0, 4'h0);
        drv_d(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
        drv_d(1'b0, BASE + 32'h20, 32'h0, 4'h0);

        drv_d(1'b0, 32'h8000_0002, 32'h0, 4'h0);
        drv_d(1'b1, 32'h8000_4000, 32'hDEAD_BEEF, 4'hF);
        drv_i(BASE);
        drv_i(32'h7FFF_FFFC);
        drain();

        // Round robin from reset with both channels held busy.
        pulse_reset();
        grant_log.delete();
        fork
            begin drv_i(BASE); drv_i(BASE + 32'h4); end
            begin drv_d(1'b0, BASE + 32'h8, 32'h0, 4'h0); drv_d(1'b0, BASE + 32'hC, 32'h0, 4'h0); end
        join
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("rr_grant_order", 32'(grant_log[k]), 32'(exp_rr[k]));
        drain();

        // Data response backpressure with a fetch waiting.
        d_rsp_ready = 1'b0;
        drv_d(1'b0, BASE + 32'h10, 32'h0, 4'h0);
        fork
            drv_i(BASE + 32'h4);
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    if (d_rsp_valid) seen = 1'b1;
                end
                if (!seen) fail_now("bp_rsp_timeout");
                for (int k = 0; k < 5; k++) begin
                    check("bp_i_ready_low", 32'(i_req_ready), 32'h0);
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk); #1;
                d_rsp_ready = 1'b1;
                @(negedge clk);
                check("bp_i_ready_ack_cycle", 32'(i_req_ready), 32'h0);
            end
        join
        check("bp_i_accept_cycle", i_hs_cyc, d_ack_cyc + 1);
        drain();

        // Reset while a store waits for its write edge.
        old9 = mdl[9];
        @(posedge clk); #1;
        d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = BASE + 32'h24;
        d_req_wdata = ~old9; d_req_wmask = 4'hF;
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                if (d_req_ready === 1'b1) ok = 1'b1;
            end
            if (!ok) fail_now("rst_store_timeout");
        end
        @(posedge clk); #1;
        i_req_valid = 1'b1; i_req_addr = BASE;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        repeat (2) @(negedge clk);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        grant_log.delete();
        fork
            drv_i(BASE);
            drv_d(1'b0, BASE + 32'h24, 32'h0, 4'h0);
        join
        check("rst_tie_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("rst_tie_first", 32'(grant_log[0]), 32'h0);
            check("rst_tie_second", 32'(grant_log[1]), 32'h1);
        end
        drain();

        // Randomised mix with response backpressure.
        rand_bp = 1'b1;
        repeat (120) begin
            int unsigned mode;
            mode = $urandom_range(0, 2);
            if (mode == 0) drv_i(rand_addr());
            else if (mode == 1) drv_d(1'($urandom), rand_addr(), $urandom, 4'($urandom));
            else fork
                drv_i(rand_addr());
                drv_d(1'($urandom), rand_addr(), $urandom, 4'($urandom));
            join
        end
        rand_bp = 1'b0;
        @(posedge clk); #1;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        drain();
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
